// File: rtl/mcp_controller_ext.sv
// mcp_controller_ext: multicycle MIPS control unit with addi/slti/bne/j,
// a memory-ready handshake, illegal-opcode flag and retired-instruction count.
//
// Parameters:
//   EXT_OPS        1: decode addi/slti/bne/j; 0: treat them as illegal
//   MEM_HANDSHAKE  1: mem_ready stretches FETCH/MEMRD/MEMWR; 0: mem_ready ignored
//   CNT_W          width of the retire counter
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   op, funct           instruction opcode and function fields
//   zero                ALU zero flag
//   mem_ready           memory access completes this cycle
//   pcen, memwrite, irwrite, regwrite   write strobes (combinational)
//   alusrca, iord, memtoreg, regdst     mux selects (combinational)
//   alusrcb, pcsrc, alucontrol          ALU/PC selects (combinational)
//   illegal_op          pulse in DECODE for an undecodable op
//   state               current state (registered, for debug)
//   instret             retired-instruction count (registered)
module mcp_controller_ext #(
  parameter bit          EXT_OPS       = 1'b1,
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_SLTIEX  = 4'd11,
    S_IWB     = 4'd12,
    S_JEX     = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic [CNT_W-1:0] instret_q;

  logic       mem_rdy;
  logic       pcwrite, branch, bne_br;
  logic [1:0] aluop;
  logic       ir_wr, mem_wr, reg_wr, illegal, retire;

  // Without the handshake every access completes in one cycle.
  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State, run flag and retire counter. run_q holds the FSM idle in FETCH
  // until the first rising edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        state_q <= state_d;
        if (retire) instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Next state and per-state control
  always_comb begin
    state_d  = state_q;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne_br   = 1'b0;
    aluop    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    ir_wr    = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        ir_wr   = mem_rdy;
        pcwrite = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        state_d = S_FETCH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE: begin
            if (EXT_OPS) state_d = S_BNEEX;
            else         illegal = 1'b1;
          end
          OP_ADDI: begin
            if (EXT_OPS) state_d = S_ADDIEX;
            else         illegal = 1'b1;
          end
          OP_SLTI: begin
            if (EXT_OPS) state_d = S_SLTIEX;
            else         illegal = 1'b1;
          end
          OP_J: begin
            if (EXT_OPS) state_d = S_JEX;
            else         illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        reg_wr   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // memwrite is held for the whole access, including wait cycles
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst  = 1'b1;
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne_br  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IWB;
      end
      S_SLTIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operation decode
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b11: alucontrol = 3'b111;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
    endcase
  end

  // Strobes are suppressed in reset and until the FSM starts running
  assign pcen       = run_q & (pcwrite | (branch & zero) | (bne_br & ~zero));
  assign irwrite    = run_q & ir_wr;
  assign memwrite   = run_q & mem_wr;
  assign regwrite   = run_q & reg_wr;
  assign illegal_op = run_q & illegal;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mcp_controller_ext.sv
// Testbench for mcp_controller_ext: reset checks, a table of single
// instructions, hand sequences for handshake/reset corner cases, and
// randomized instruction streams checked against a trace-based model.
module tb_mcp_controller_ext;

  localparam int unsigned CNT_W = 16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk;
  logic reset;
  logic [5:0] op, funct;
  logic zero, mem_ready;

  logic pcen0, memwrite0, irwrite0, regwrite0, alusrca0, iord0, memtoreg0, regdst0, ill0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] aluc0;
  logic [3:0] st0;
  logic [CNT_W-1:0] cnt0;

  logic pcen1, memwrite1, irwrite1, regwrite1, alusrca1, iord1, memtoreg1, regdst1, ill1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] aluc1;
  logic [3:0] st1;
  logic [CNT_W-1:0] cnt1;

  mcp_controller_ext #(.EXT_OPS(1'b1), .MEM_HANDSHAKE(1'b1), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
    .alusrca(alusrca0), .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(aluc0), .illegal_op(ill0),
    .state(st0), .instret(cnt0));

  mcp_controller_ext #(.EXT_OPS(1'b0), .MEM_HANDSHAKE(1'b0), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen1), .memwrite(memwrite1), .irwrite(irwrite1), .regwrite(regwrite1),
    .alusrca(alusrca1), .iord(iord1), .memtoreg(memtoreg1), .regdst(regdst1),
    .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(aluc1), .illegal_op(ill1),
    .state(st1), .instret(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic ill;
  } obs_t;

  obs_t obs0, obs1;
  assign obs0 = {st0, pcen0, memwrite0, irwrite0, regwrite0, alusrca0, iord0, memtoreg0,
                 regdst0, alusrcb0, pcsrc0, aluc0, ill0};
  assign obs1 = {st1, pcen1, memwrite1, irwrite1, regwrite1, alusrca1, iord1, memtoreg1,
                 regdst1, alusrcb1, pcsrc1, aluc1, ill1};

  // Per-state control word as listed in the state table
  typedef struct packed {
    logic a, fetch, pcwrite, branch, bne, iord, memtoreg, regdst, regwrite, memwrite;
    logic [1:0] b, pcsrc, aluop;
  } ctl_t;
  ctl_t ctl_tab [16];

  logic [5:0] fn_key [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] fn_val [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  logic [2:0] aluop_val [4] = '{3'b010, 3'b110, 3'b000, 3'b111};
  logic [5:0] legal_ops [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_J};

  typedef struct packed { obs_t e; logic mr; } step_t;
  step_t exp_q[$];

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cycles;
    int         ill_cycles;
    int         retired;
    int         pcen_cycles;
  } vec_t;
  vec_t vtab [12];

  int n_chk, n_pass;
  logic [CNT_W-1:0] ret [2];
  obs_t rexp;
  int n, ill_n, pc_n;
  logic [CNT_W-1:0] c_before;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic bit is_legal(input logic [5:0] o, input bit ext);
    if (o inside {OP_R, OP_LW, OP_SW, OP_BEQ}) return 1'b1;
    if (ext && (o inside {OP_BNE, OP_ADDI, OP_SLTI, OP_J})) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] funct_dec(input logic [5:0] f);
    for (int k = 0; k < 5; k++) if (fn_key[k] == f) return fn_val[k];
    return 3'b000;
  endfunction

  function automatic obs_t expect_out(input logic [3:0] s, input logic mr_eff, input logic z,
                                      input logic [5:0] o, input logic [5:0] f, input bit ext);
    ctl_t c;
    obs_t r;
    c = ctl_tab[s];
    r = '0;
    r.st       = s;
    r.irwrite  = c.fetch & mr_eff;
    r.pcen     = (c.fetch & mr_eff) | c.pcwrite | (c.branch & z) | (c.bne & ~z);
    r.memwrite = c.memwrite;
    r.regwrite = c.regwrite;
    r.alusrca  = c.a;
    r.iord     = c.iord;
    r.memtoreg = c.memtoreg;
    r.regdst   = c.regdst;
    r.alusrcb  = c.b;
    r.pcsrc    = c.pcsrc;
    r.aluc     = (c.aluop == 2'b10) ? funct_dec(f) : aluop_val[c.aluop];
    r.ill      = (s == 4'd1) && !is_legal(o, ext);
    return r;
  endfunction

  // Build the expected cycle trace of one instruction into exp_q
  function automatic void build(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input bit ext, input bit hs, input int fw, input int mw);
    logic [3:0] path[$];
    logic mr;
    int w;
    step_t sp;
    path.push_back(4'd0);
    path.push_back(4'd1);
    if (is_legal(o, ext)) begin
      if (o == OP_LW) begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      else if (o == OP_SW) begin path.push_back(4'd2); path.push_back(4'd5); end
      else if (o == OP_R) begin path.push_back(4'd6); path.push_back(4'd7); end
      else if (o == OP_BEQ) path.push_back(4'd8);
      else if (o == OP_BNE) path.push_back(4'd9);
      else if (o == OP_ADDI) begin path.push_back(4'd10); path.push_back(4'd12); end
      else if (o == OP_SLTI) begin path.push_back(4'd11); path.push_back(4'd12); end
      else path.push_back(4'd13);
    end
    foreach (path[k]) begin
      if (hs && (path[k] == 4'd0 || path[k] == 4'd3 || path[k] == 4'd5)) begin
        w = (path[k] == 4'd0) ? fw : mw;
        for (int j = 0; j < w; j++) begin
          sp.e = expect_out(path[k], 1'b0, z, o, f, ext);
          sp.mr = 1'b0;
          exp_q.push_back(sp);
        end
        sp.e = expect_out(path[k], 1'b1, z, o, f, ext);
        sp.mr = 1'b1;
        exp_q.push_back(sp);
      end else begin
        mr = 1'($urandom);
        sp.e = expect_out(path[k], hs ? mr : 1'b1, z, o, f, ext);
        sp.mr = mr;
        exp_q.push_back(sp);
      end
    end
  endfunction

  // Drive one instruction from FETCH and check every cycle of it
  task automatic run_instr(input int which, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input bit ext, input bit hs, input int fw, input int mw);
    obs_t got;
    logic [CNT_W-1:0] cnt;
    exp_q.delete();
    build(o, f, z, ext, hs, fw, mw);
    op = o; funct = f; zero = z;
    foreach (exp_q[i]) begin
      mem_ready = exp_q[i].mr;
      @(negedge clk);
      got = (which == 1) ? obs1 : obs0;
      cnt = (which == 1) ? cnt1 : cnt0;
      chk($sformatf("dut%0d op=%b step%0d outputs", which, o, i), 64'(got), 64'(exp_q[i].e));
      chk($sformatf("dut%0d op=%b step%0d instret", which, o, i), 64'(cnt), 64'(ret[which]));
      @(posedge clk); #1;
    end
    if (is_legal(o, ext)) ret[which] = ret[which] + CNT_W'(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    ret[0] = '0; ret[1] = '0;
    for (int s = 0; s < 16; s++) ctl_tab[s] = '0;
    ctl_tab[0].b = 2'b01;  ctl_tab[0].fetch = 1'b1;
    ctl_tab[1].b = 2'b11;
    ctl_tab[2].a = 1'b1;   ctl_tab[2].b = 2'b10;
    ctl_tab[3].iord = 1'b1;
    ctl_tab[4].memtoreg = 1'b1; ctl_tab[4].regwrite = 1'b1;
    ctl_tab[5].iord = 1'b1; ctl_tab[5].memwrite = 1'b1;
    ctl_tab[6].a = 1'b1;   ctl_tab[6].aluop = 2'b10;
    ctl_tab[7].regdst = 1'b1; ctl_tab[7].regwrite = 1'b1;
    ctl_tab[8].a = 1'b1;   ctl_tab[8].aluop = 2'b01; ctl_tab[8].pcsrc = 2'b01; ctl_tab[8].branch = 1'b1;
    ctl_tab[9].a = 1'b1;   ctl_tab[9].aluop = 2'b01; ctl_tab[9].pcsrc = 2'b01; ctl_tab[9].bne = 1'b1;
    ctl_tab[10].a = 1'b1;  ctl_tab[10].b = 2'b10;
    ctl_tab[11].a = 1'b1;  ctl_tab[11].b = 2'b10; ctl_tab[11].aluop = 2'b11;
    ctl_tab[12].regwrite = 1'b1;
    ctl_tab[13].pcsrc = 2'b10; ctl_tab[13].pcwrite = 1'b1;

    // op, funct, zero, cycles, illegal_op cycles, retired, pcen cycles
    vtab[0]  = '{OP_LW,   6'b000000, 1'b0, 5, 0, 1, 1};
    vtab[1]  = '{OP_SW,   6'b000000, 1'b0, 4, 0, 1, 1};
    vtab[2]  = '{OP_R,    6'b100000, 1'b1, 4, 0, 1, 1};
    vtab[3]  = '{OP_BEQ,  6'b000000, 1'b1, 3, 0, 1, 2};
    vtab[4]  = '{OP_BEQ,  6'b000000, 1'b0, 3, 0, 1, 1};
    vtab[5]  = '{OP_BNE,  6'b000000, 1'b0, 3, 0, 1, 2};
    vtab[6]  = '{OP_BNE,  6'b000000, 1'b1, 3, 0, 1, 1};
    vtab[7]  = '{OP_ADDI, 6'b000000, 1'b0, 4, 0, 1, 1};
    vtab[8]  = '{OP_SLTI, 6'b000000, 1'b0, 4, 0, 1, 1};
    vtab[9]  = '{OP_J,    6'b000000, 1'b0, 3, 0, 1, 2};
    vtab[10] = '{6'b111111, 6'b000000, 1'b0, 2, 1, 0, 1};
    vtab[11] = '{6'b000001, 6'b000000, 1'b1, 2, 1, 0, 1};

    rexp = '0;
    rexp.alusrcb = 2'b01;
    rexp.aluc = 3'b010;

    // Reset: mem_ready high would otherwise raise irwrite/pcen in FETCH
    reset = 1'b1; op = OP_LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset outputs dut0", 64'(obs0), 64'(rexp));
    chk("reset instret dut0", 64'(cnt0), 64'd0);
    chk("reset outputs dut1", 64'(obs1), 64'(rexp));
    @(posedge clk); #1;
    chk("reset held across edge", 64'(obs0), 64'(rexp));
    @(negedge clk) reset = 1'b1;
    #1 chk("released before first edge", 64'(obs0), 64'(rexp));
    @(posedge clk); #1;
    chk("first edge after release stays FETCH", 64'(st0), 64'd0);

    // Hand sequences on dut0
    run_instr(0, OP_LW, 6'b000000, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(0, OP_SW, 6'b000000, 1'b0, 1'b1, 1'b1, 0, 2);
    run_instr(0, OP_R, 6'b101010, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(0, OP_R, 6'b100010, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(0, OP_BEQ, 6'b000000, 1'b1, 1'b1, 1'b1, 0, 0);
    run_instr(0, OP_BEQ, 6'b000000, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(0, OP_BNE, 6'b000000, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(0, OP_J, 6'b000000, 1'b0, 1'b1, 1'b1, 2, 0);
    run_instr(0, 6'b111111, 6'b000000, 1'b0, 1'b1, 1'b1, 1, 0);
    run_instr(0, OP_LW, 6'b000000, 1'b0, 1'b1, 1'b1, 1, 3);

    // Table of single instructions with zero wait states
    for (int i = 0; i < 12; i++) begin
      op = vtab[i].op; funct = vtab[i].funct; zero = vtab[i].zero; mem_ready = 1'b1;
      n = 0; ill_n = 0; pc_n = 0; c_before = cnt0;
      do begin
        @(negedge clk);
        ill_n += int'(ill0);
        pc_n += int'(pcen0);
        @(posedge clk); #1;
        n++;
      end while (st0 != 4'd0 && n < 20);
      chk($sformatf("vec%0d cycles", i), 64'(n), 64'(vtab[i].cycles));
      chk($sformatf("vec%0d illegal_op cycles", i), 64'(ill_n), 64'(vtab[i].ill_cycles));
      chk($sformatf("vec%0d pcen cycles", i), 64'(pc_n), 64'(vtab[i].pcen_cycles));
      chk($sformatf("vec%0d retired", i), 64'(CNT_W'(cnt0 - c_before)), 64'(vtab[i].retired));
      ret[0] = ret[0] + CNT_W'(vtab[i].retired);
    end

    // Randomized instruction stream on dut0
    for (int i = 0; i < 80; i++) begin
      logic [5:0] ro, rf;
      int sel;
      sel = int'($urandom_range(0, 9));
      ro = (sel < 8) ? legal_ops[sel] : 6'($urandom);
      sel = int'($urandom_range(0, 5));
      rf = (sel < 5) ? fn_key[sel] : 6'($urandom);
      run_instr(0, ro, rf, 1'($urandom), 1'b1, 1'b1,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Reset asserted while lw waits in MEMRD
    op = OP_LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("reached MEMRD", 64'(st0), 64'd3);
    chk("instret before abort", 64'(cnt0), 64'(ret[0]));
    #2 reset = 1'b0;
    #1;
    chk("abort outputs dut0", 64'(obs0), 64'(rexp));
    chk("abort instret dut0", 64'(cnt0), 64'd0);
    chk("abort outputs dut1", 64'(obs1), 64'(rexp));
    chk("abort instret dut1", 64'(cnt1), 64'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort held across edge", 64'(obs0), 64'(rexp));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("restart in FETCH", 64'(st0), 64'd0);
    ret[0] = '0; ret[1] = '0;

    // dut1: extended ops illegal, mem_ready ignored
    run_instr(1, OP_ADDI, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, OP_LW, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, OP_J, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, OP_SW, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, OP_BNE, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, OP_SLTI, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1, OP_R, 6'b100101, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("dut1 final instret", 64'(cnt1), 64'(ret[1]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
